// File: rtl/wb_pipe_mem.sv
// Pipelined Wishbone memory with a fixed accept-to-response delay line,
// outstanding-request limiting, and abort on cycle drop.
module wb_pipe_mem #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int LGMEMLEN      = 10,
  parameter int DW            = 32,
  parameter int LATENCY       = 2,
  parameter int LGMAXOUT      = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [ADDRESS_WIDTH-1:0] i_wb_addr,
  input  logic [DW-1:0]            i_wb_data,
  output logic                     o_wb_ack,
  output logic                     o_wb_stall,
  output logic [DW-1:0]            o_wb_data,
  output logic                     o_wb_err
);

  localparam logic [LGMAXOUT:0] MAXOUT = {1'b1, {LGMAXOUT{1'b0}}};

  logic [DW-1:0]      r_mem [0:(1<<LGMEMLEN)-1];
  logic [LATENCY-1:0] r_valid = '0;
  logic [LATENCY-1:0] r_err   = '0;
  logic [DW-1:0]      r_data [LATENCY] = '{default: '0};
  logic [LGMAXOUT:0]  r_nout  = '0;

  logic                w_accept;
  logic                w_oor;
  logic                w_resp;
  logic                w_flush;
  logic [LGMEMLEN-1:0] w_idx;

  generate
    if (ADDRESS_WIDTH > LGMEMLEN) begin : g_range
      assign w_oor = |i_wb_addr[ADDRESS_WIDTH-1:LGMEMLEN];
    end else begin : g_norange
      assign w_oor = 1'b0;
    end
  endgenerate

  // Handshake: a request transfers on any edge where cyc && stb && !stall;
  // stall depends only on registered state and reset, never on stb.
  assign w_idx      = i_wb_addr[LGMEMLEN-1:0];
  assign o_wb_stall = (r_nout == MAXOUT) || i_rst;
  assign w_accept   = i_wb_cyc && i_wb_stb && !o_wb_stall;
  assign w_flush    = i_rst || !i_wb_cyc;
  assign w_resp     = i_wb_cyc && r_valid[LATENCY-1];
  assign o_wb_ack   = w_resp && !r_err[LATENCY-1];
  assign o_wb_err   = w_resp && r_err[LATENCY-1];
  assign o_wb_data  = r_data[LATENCY-1];

  // Memory and data lane are not reset: contents survive reset and abort.
  always_ff @(posedge i_clk) begin
    if (w_accept && !w_oor && i_wb_we)
      r_mem[w_idx] <= i_wb_data;
    r_data[0] <= (w_accept && !w_oor && !i_wb_we) ? r_mem[w_idx] : '0;
    for (int i = 1; i < LATENCY; i++)
      r_data[i] <= r_data[i-1];
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_valid <= '0;
      r_err   <= '0;
      r_nout  <= '0;
    end else begin
      r_valid[0] <= w_accept;
      r_err[0]   <= w_accept && w_oor;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
      end
      if (w_accept && !w_resp)
        r_nout <= r_nout + 1'b1;
      else if (!w_accept && w_resp)
        r_nout <= r_nout - 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_pipe_mem.sv
// Bench for wb_pipe_mem: three instances (L=2/MAX=4, L=3/MAX=2, L=4/MAX=4)
// checked every cycle against a due-time response queue model.
module tb_wb_pipe_mem;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc_s   [NI];
  logic        stb_s   [NI];
  logic        we_s    [NI];
  logic [11:0] addr_s  [NI];
  logic [31:0] wdat_s  [NI];
  logic        ack_s   [NI];
  logic        stall_s [NI];
  logic        err_s   [NI];
  logic [31:0] rdat_s  [NI];

  wb_pipe_mem #(.ADDRESS_WIDTH(12), .LGMEMLEN(10), .DW(32), .LATENCY(2), .LGMAXOUT(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc_s[0]), .i_wb_stb(stb_s[0]), .i_wb_we(we_s[0]),
    .i_wb_addr(addr_s[0]), .i_wb_data(wdat_s[0]), .o_wb_ack(ack_s[0]), .o_wb_stall(stall_s[0]),
    .o_wb_data(rdat_s[0]), .o_wb_err(err_s[0]));

  wb_pipe_mem #(.ADDRESS_WIDTH(12), .LGMEMLEN(10), .DW(32), .LATENCY(3), .LGMAXOUT(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc_s[1]), .i_wb_stb(stb_s[1]), .i_wb_we(we_s[1]),
    .i_wb_addr(addr_s[1]), .i_wb_data(wdat_s[1]), .o_wb_ack(ack_s[1]), .o_wb_stall(stall_s[1]),
    .o_wb_data(rdat_s[1]), .o_wb_err(err_s[1]));

  wb_pipe_mem #(.ADDRESS_WIDTH(12), .LGMEMLEN(10), .DW(32), .LATENCY(4), .LGMAXOUT(2)) u_c (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc_s[2]), .i_wb_stb(stb_s[2]), .i_wb_we(we_s[2]),
    .i_wb_addr(addr_s[2]), .i_wb_data(wdat_s[2]), .o_wb_ack(ack_s[2]), .o_wb_stall(stall_s[2]),
    .o_wb_data(rdat_s[2]), .o_wb_err(err_s[2]));

  function automatic int lat(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int maxo(input int i);
    return (i == 1) ? 2 : 4;
  endfunction

  // Model: word memory plus a FIFO of pending responses, each with its due cycle.
  logic [31:0] mdl_mem [NI][1024];
  int          pq_due  [NI][8];
  logic        pq_err  [NI][8];
  logic [31:0] pq_dat  [NI][8];
  int          pq_hd   [NI];
  int          pq_cnt  [NI];

  // Log of every response the DUTs produced, for literal checks.
  int          log_cyc [NI][64];
  logic        log_err [NI][64];
  logic [31:0] log_dat [NI][64];
  int          log_n   [NI];

  int n      = 0;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic mon_step(input int i);
    automatic logic e_stall, e_resp, e_err, oor;
    automatic int   slot;
    e_stall = rst || (pq_cnt[i] == maxo(i));
    e_resp  = cyc_s[i] && (pq_cnt[i] > 0) && (pq_due[i][pq_hd[i]] == n);
    e_err   = e_resp && pq_err[i][pq_hd[i]];
    chk($sformatf("stall%0d", i), 32'(stall_s[i]), 32'(e_stall));
    chk($sformatf("ack%0d", i), 32'(ack_s[i]), 32'(e_resp && !e_err));
    chk($sformatf("err%0d", i), 32'(err_s[i]), 32'(e_err));
    if (e_resp)
      chk($sformatf("data%0d", i), rdat_s[i], pq_dat[i][pq_hd[i]]);
    if ((ack_s[i] || err_s[i]) && log_n[i] < 64) begin
      log_cyc[i][log_n[i]] = n;
      log_err[i][log_n[i]] = err_s[i];
      log_dat[i][log_n[i]] = rdat_s[i];
      log_n[i]++;
    end
    if (rst || !cyc_s[i]) begin
      pq_cnt[i] = 0;
    end else begin
      if (e_resp) begin
        pq_hd[i] = (pq_hd[i] + 1) % 8;
        pq_cnt[i]--;
      end
      if (stb_s[i] && !e_stall) begin
        oor  = (int'(addr_s[i]) >= 1024);
        slot = (pq_hd[i] + pq_cnt[i]) % 8;
        pq_due[i][slot] = n + lat(i);
        pq_err[i][slot] = oor;
        pq_dat[i][slot] = (oor || we_s[i]) ? 32'd0 : mdl_mem[i][addr_s[i][9:0]];
        if (!oor && we_s[i])
          mdl_mem[i][addr_s[i][9:0]] = wdat_s[i];
        pq_cnt[i]++;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++)
      mon_step(i);
    n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  // Presents one request and holds it until the DUT takes it.
  task automatic req(input int i, input logic we, input logic [11:0] addr,
                     input logic [31:0] d, output int acc_n, output int tries);
    automatic logic done = 1'b0;
    tries = 0;
    acc_n = -1;
    cyc_s[i] = 1'b1; stb_s[i] = 1'b1; we_s[i] = we; addr_s[i] = addr; wdat_s[i] = d;
    while (!done && tries < 32) begin
      acc_n = n;
      tries++;
      @(negedge clk);
      done = !stall_s[i];
      tick();
    end
    stb_s[i] = 1'b0;
    chk($sformatf("req_accept%0d", i), 32'(done), 32'd1);
  endtask

  task automatic chk_log(input int i, input int idx, input int ecyc,
                         input logic eerr, input logic [31:0] edat, input string tag);
    if (idx >= log_n[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: response %0d missing, got %0d responses", tag, idx, log_n[i]);
    end else begin
      chk({tag, "_cycle"}, 32'(log_cyc[i][idx]), 32'(ecyc));
      chk({tag, "_err"}, 32'(log_err[i][idx]), 32'(eerr));
      chk({tag, "_data"}, log_dat[i][idx], edat);
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    automatic int c1, c2, c3, c4, t, b, stalls;
    automatic int acc [4];
    for (int i = 0; i < NI; i++) begin
      cyc_s[i] = 1'b0; stb_s[i] = 1'b0; we_s[i] = 1'b0;
      addr_s[i] = '0; wdat_s[i] = '0;
      pq_hd[i] = 0; pq_cnt[i] = 0; log_n[i] = 0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Write then read back on the L=2 instance.
    b = log_n[0];
    req(0, 1'b1, 12'd5, 32'hDEADBEEF, c1, t);
    req(0, 1'b0, 12'd5, 32'h0, c2, t);
    idle(4);
    chk("t1_count", 32'(log_n[0] - b), 32'd2);
    chk_log(0, b, c1 + 2, 1'b0, 32'h0, "t1_wr");
    chk_log(0, b + 1, c2 + 2, 1'b0, 32'hDEADBEEF, "t1_rd");

    // Preload 0..3 with 1..4, then four back-to-back reads.
    for (int k = 0; k < 4; k++)
      req(0, 1'b1, 12'(k), 32'(k + 1), c1, t);
    idle(3);
    b = log_n[0];
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      req(0, 1'b0, 12'(k), 32'h0, acc[k], t);
      stalls += t - 1;
    end
    idle(4);
    chk("t2_stalls", 32'(stalls), 32'd0);
    for (int k = 0; k < 4; k++)
      chk_log(0, b + k, acc[0] + 2 + k, 1'b0, 32'(k + 1), $sformatf("t2_rd%0d", k));

    // L=3, MAXOUT=2: strobes held across the stall window.
    for (int k = 0; k < 4; k++)
      req(1, 1'b1, 12'(k), 32'(16 + k), c1, t);
    idle(6);
    b = log_n[1];
    for (int k = 0; k < 4; k++)
      req(1, 1'b0, 12'(k), 32'h0, acc[k], t);
    idle(8);
    chk("t3_acc1", 32'(acc[1] - acc[0]), 32'd1);
    chk("t3_acc2", 32'(acc[2] - acc[0]), 32'd4);
    chk("t3_acc3", 32'(acc[3] - acc[0]), 32'd5);
    chk_log(1, b,     acc[0] + 3, 1'b0, 32'h10, "t3_rd0");
    chk_log(1, b + 1, acc[0] + 4, 1'b0, 32'h11, "t3_rd1");
    chk_log(1, b + 2, acc[0] + 7, 1'b0, 32'h12, "t3_rd2");
    chk_log(1, b + 3, acc[0] + 8, 1'b0, 32'h13, "t3_rd3");

    // Out-of-range write must error and leave word 0 alone.
    b = log_n[0];
    req(0, 1'b1, 12'h400, 32'h12345678, c1, t);
    req(0, 1'b0, 12'h000, 32'h0, c2, t);
    idle(4);
    chk("t4_count", 32'(log_n[0] - b), 32'd2);
    chk_log(0, b, c1 + 2, 1'b1, 32'h0, "t4_err");
    chk_log(0, b + 1, c2 + 2, 1'b0, 32'h1, "t4_rd0");

    // Abort with two reads outstanding.
    b = log_n[0];
    req(0, 1'b0, 12'd1, 32'h0, c1, t);
    req(0, 1'b0, 12'd2, 32'h0, c2, t);
    cyc_s[0] = 1'b0;
    tick();
    cyc_s[0] = 1'b1;
    @(negedge clk);
    chk("t5_nout", 32'(u_a.r_nout), 32'd0);
    chk("t5_stall", 32'(stall_s[0]), 32'd0);
    idle(3);
    chk("t5_count", 32'(log_n[0] - b), 32'd0);
    req(0, 1'b0, 12'd3, 32'h0, c3, t);
    idle(4);
    chk_log(0, b, c3 + 2, 1'b0, 32'h4, "t5_rd3");

    // Reset with three reads outstanding on the L=4 instance.
    req(2, 1'b1, 12'd7, 32'hA5A50007, c1, t);
    idle(6);
    b = log_n[2];
    req(2, 1'b0, 12'd7, 32'h0, c1, t);
    req(2, 1'b0, 12'd7, 32'h0, c2, t);
    req(2, 1'b0, 12'd7, 32'h0, c3, t);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_stall_rst", 32'(stall_s[2]), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_stall_after", 32'(stall_s[2]), 32'd0);
    idle(6);
    chk("t6_count", 32'(log_n[2] - b), 32'd0);
    req(2, 1'b0, 12'd7, 32'h0, c4, t);
    idle(6);
    chk_log(2, b, c4 + 4, 1'b0, 32'hA5A50007, "t6_rd7");

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
